// File: rtl/add3_chunk_sequencer_if.sv
// Operand/result handshake bundle for add3_chunk_sequencer.
// master: operand producer and result consumer. slave: the sequencer.
// Both channels use valid/ready: a transfer happens on a rising clock edge
// where valid and ready are both high; valid must not depend on ready.
interface add3_chunk_sequencer_if #(
    parameter int NCHUNK = 4
);
    localparam int W = 3 * NCHUNK;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin_init;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry_out;

    modport master (
        output in_valid, a, b, cin_init, sub, out_ready,
        input  in_ready, out_valid, result, carry_out
    );

    modport slave (
        input  in_valid, a, b, cin_init, sub, out_ready,
        output in_ready, out_valid, result, carry_out
    );
endinterface

// File: rtl/add3_chunk_sequencer.sv
// add3_chunk_sequencer: feeds W = 3*NCHUNK bit operands through an external
// 3-bit ripple adder slice, one chunk per cycle, LSB chunk first, chaining
// cout back into cin, and returns the W-bit result plus the final carry.
// Optional macro SUBTRACT_EN: when defined, sub=1 at acceptance computes A-B
// (B inverted, initial carry forced to 1); otherwise sub is ignored.
// dbg_state exposes the FSM state (0=IDLE, 1=RUN, 2=DONE).
module add3_chunk_sequencer #(
    parameter int NCHUNK = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    add3_chunk_sequencer_if.slave  io,
    output logic [2:0]             add_x,
    output logic [2:0]             add_y,
    output logic                   add_cin,
    input  logic [2:0]             add_sum,
    input  logic                   add_cout,
    output logic [1:0]             dbg_state
);
    localparam int W  = 3 * NCHUNK;
    localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic          carry_q, carry_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  result_q, result_d;
    logic          carry_out_q, carry_out_d;
    logic          eff_sub;
    int unsigned   bit_base;

`ifdef SUBTRACT_EN
    assign eff_sub = io.sub;
`else
    // Subtraction is compiled out; sub is accepted on the port but has no effect.
    logic unused_sub;
    assign unused_sub = io.sub;
    assign eff_sub    = 1'b0;
`endif

    // Handshake flags and debug state are pure decodes of the FSM state.
    assign io.in_ready  = (state_q == S_IDLE);
    assign io.out_valid = (state_q == S_DONE);
    assign io.result    = result_q;
    assign io.carry_out = carry_out_q;
    assign dbg_state    = state_q;

    // Next-state, datapath updates and slice drive for the current chunk.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        idx_d       = idx_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        add_x       = 3'd0;
        add_y       = 3'd0;
        add_cin     = 1'b0;
        bit_base    = 32'(idx_q) * 32'd3;
        case (state_q)
            S_IDLE: begin
                if (io.in_valid) begin
                    a_d     = io.a;
                    b_d     = eff_sub ? ~io.b : io.b;
                    carry_d = eff_sub ? 1'b1 : io.cin_init;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                add_x   = a_q[bit_base +: 3];
                add_y   = b_q[bit_base +: 3];
                add_cin = carry_q;
                result_d[bit_base +: 3] = add_sum;
                carry_d = add_cout;
                if (idx_q == LAST_IDX) begin
                    carry_out_d = add_cout;
                    idx_d       = '0;
                    state_d     = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                // Input is deliberately not sampled here: a new operation can
                // only be accepted after returning to IDLE.
                if (io.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
        end
    end
endmodule

// File: tb/tb_add3_chunk_sequencer.sv
// Directed bench for add3_chunk_sequencer (NCHUNK=4, W=12) with a
// behavioural 3-bit adder slice closing the loop.
module tb_add3_chunk_sequencer;
    localparam int NCHUNK = 4;
    localparam int W      = 3 * NCHUNK;

    logic       clk;
    logic       rst_n;
    logic [2:0] add_x, add_y, add_sum;
    logic       add_cin, add_cout;
    logic [1:0] dbg_state;
    logic [3:0] slice_full;

    int vectors;
    int miscompares;

    add3_chunk_sequencer_if #(.NCHUNK(NCHUNK)) io ();

    add3_chunk_sequencer #(.NCHUNK(NCHUNK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .io        (io),
        .add_x     (add_x),
        .add_y     (add_y),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .dbg_state (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural adder slice (combinational)
    assign slice_full = {1'b0, add_x} + {1'b0, add_y} + {3'b000, add_cin};
    assign add_sum    = slice_full[2:0];
    assign add_cout   = slice_full[3];

    task automatic test_reset();
        rst_n        = 1'b0;
        io.in_valid  = 1'b0;
        io.a         = '0;
        io.b         = '0;
        io.cin_init  = 1'b0;
        io.sub       = 1'b0;
        io.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (io.in_ready !== 1'b1 || io.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1 0", io.in_ready, io.out_valid);
        end
        vectors++;
        if (io.result !== 12'h000 || io.carry_out !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_res: result=%h carry_out=%b want 000 0", io.result, io.carry_out);
        end
        vectors++;
        if (add_x !== 3'd0 || add_y !== 3'd0 || add_cin !== 1'b0 || dbg_state !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_slice: x=%h y=%h cin=%b st=%h want 0 0 0 0", add_x, add_y, add_cin, dbg_state);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One full operation: accept, watch the carry chain, check result, drain.
    task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub, input logic early_ready,
                         input logic [W-1:0] exp_res, input logic exp_c, input logic [3:0] exp_cin);
        int          cyc;
        logic [31:0] seen;
        vectors++;
        if (io.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_idle: in_ready=%b want 1", name, io.in_ready);
        end
        io.a         = a;
        io.b         = b;
        io.cin_init  = cin;
        io.sub       = sub;
        io.in_valid  = 1'b1;
        io.out_ready = early_ready;
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        cyc  = 0;
        seen = '0;
        while (io.out_valid !== 1'b1 && cyc < 20) begin
            seen[cyc] = add_cin;
            @(posedge clk);
            #1;
            cyc++;
        end
        vectors++;
        if (cyc != NCHUNK) begin
            miscompares++;
            $display("FAIL %s_latency: edges=%0d want %0d", name, cyc, NCHUNK);
        end
        vectors++;
        if (seen[3:0] !== exp_cin) begin
            miscompares++;
            $display("FAIL %s_cin_chain: seen=%b want %b", name, seen[3:0], exp_cin);
        end
        vectors++;
        if (io.result !== exp_res || io.carry_out !== exp_c) begin
            miscompares++;
            $display("FAIL %s_result: result=%h carry=%b want %h %b", name, io.result, io.carry_out, exp_res, exp_c);
        end
        io.out_ready = 1'b1;
        @(posedge clk);
        #1;
        io.out_ready = 1'b0;
        vectors++;
        if (io.out_valid !== 1'b0 || io.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_drain: out_valid=%b in_ready=%b want 0 1", name, io.out_valid, io.in_ready);
        end
    endtask

    task automatic test_add();
        do_op("abc_123", 12'hABC, 12'h123, 1'b0, 1'b0, 1'b0, 12'hBDF, 1'b0, 4'b0100);
        do_op("fff_001", 12'hFFF, 12'h001, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 4'b1110);
        do_op("zero_cin", 12'h000, 12'h000, 1'b1, 1'b0, 1'b0, 12'h001, 1'b0, 4'b0001);
        do_op("wrap_max", 12'hFFF, 12'hFFF, 1'b1, 1'b0, 1'b0, 12'hFFF, 1'b1, 4'b1111);
    endtask

    task automatic test_early_ready();
        do_op("early_rdy", 12'h111, 12'h222, 1'b0, 1'b0, 1'b1, 12'h333, 1'b0, 4'b0000);
    endtask

    task automatic test_back_pressure();
        int cyc;
        io.a        = 12'h111;
        io.b        = 12'h222;
        io.cin_init = 1'b0;
        io.sub      = 1'b0;
        io.in_valid = 1'b1;
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        cyc = 0;
        while (io.out_valid !== 1'b1 && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        vectors++;
        if (io.out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_done: out_valid=%b want 1", io.out_valid);
        end
        io.a        = 12'h700;
        io.b        = 12'h100;
        io.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (io.in_ready !== 1'b0 || io.out_valid !== 1'b1 || io.result !== 12'h333 || io.carry_out !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold%0d: in_ready=%b out_valid=%b result=%h carry=%b want 0 1 333 0",
                         i, io.in_ready, io.out_valid, io.result, io.carry_out);
            end
        end
        io.out_ready = 1'b1;
        @(posedge clk);
        #1;
        io.out_ready = 1'b0;
        vectors++;
        if (io.in_ready !== 1'b1 || io.out_valid !== 1'b0 || dbg_state !== 2'd0) begin
            miscompares++;
            $display("FAIL bp_no_overlap: in_ready=%b out_valid=%b st=%h want 1 0 0", io.in_ready, io.out_valid, dbg_state);
        end
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        vectors++;
        if (io.in_ready !== 1'b0 || dbg_state !== 2'd1) begin
            miscompares++;
            $display("FAIL bp_second_accept: in_ready=%b st=%h want 0 1", io.in_ready, dbg_state);
        end
        repeat (NCHUNK) @(posedge clk);
        #1;
        vectors++;
        if (io.out_valid !== 1'b1 || io.result !== 12'h800 || io.carry_out !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_second_result: out_valid=%b result=%h carry=%b want 1 800 0", io.out_valid, io.result, io.carry_out);
        end
        io.out_ready = 1'b1;
        @(posedge clk);
        #1;
        io.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        io.a        = 12'h155;
        io.b        = 12'h2AA;
        io.cin_init = 1'b0;
        io.sub      = 1'b0;
        io.in_valid = 1'b1;
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (add_x !== 3'd2 || add_y !== 3'd5 || dbg_state !== 2'd1) begin
            miscompares++;
            $display("FAIL mid_run_chunk1: x=%h y=%h st=%h want 2 5 1", add_x, add_y, dbg_state);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (io.out_valid !== 1'b0 || io.result !== 12'h000 || io.in_ready !== 1'b1 || add_x !== 3'd0 || add_cin !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: out_valid=%b result=%h in_ready=%b x=%h cin=%b want 0 000 1 0 0",
                     io.out_valid, io.result, io.in_ready, add_x, add_cin);
        end
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_op("after_rst", 12'h007, 12'h001, 1'b0, 1'b0, 1'b0, 12'h008, 1'b0, 4'b0010);
    endtask

    task automatic test_subtract();
`ifdef SUBTRACT_EN
        do_op("sub_5_7", 12'h005, 12'h007, 1'b0, 1'b1, 1'b0, 12'hFFE, 1'b0, 4'b0001);
        do_op("sub_7_5", 12'h007, 12'h005, 1'b0, 1'b1, 1'b0, 12'h002, 1'b1, 4'b1111);
`else
        do_op("sub_ignored", 12'h005, 12'h007, 1'b0, 1'b1, 1'b0, 12'h00C, 1'b0, 4'b0010);
`endif
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_add();
        test_early_ready();
        test_back_pressure();
        test_reset_mid_op();
        test_subtract();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
